dram_sched_ctrl: RTL and testbench

Sequencing and arbitration controller for the dual-port matrix DRAM (16 × 16-bit) in the 4x4 systolic design. Port B is owned by a read sequencer that streams a block of consecutive words to the systolic array over a valid/ready interface with full backpressure. Port A is shared by two write requesters: the host loader and the array result writeback. The block sits between the DRAM instance, the host bus and the array edge feeder.

---
 rtl/dram_sched_pkg.sv | 19 +
 rtl/dram_porta_arb.sv | 80 ++++++++
 rtl/dram_sched_ctrl.sv | 144 ++++++++++++++
 tb/tb_dram_sched_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_sched_pkg.sv
// Shared definitions for the matrix DRAM sequencing/arbitration controller.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package dram_sched_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 16;

   // Read sequencer states
   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } state_t;

   // Requester indices for the port A arbiter
   localparam logic HOST = 1'b0;
   localparam logic RES  = 1'b1;

endpackage

// File: rtl/dram_porta_arb.sv
// Port A write arbiter between host loader and result writeback (DRAM_SCHED_RR_EN: round-robin, else result-first).
// Latency: 0 cycles, grant is combinational from req; the write lands on the edge ending the grant cycle.
// Backpressure: a losing requester simply holds req/addr/data until it sees its grant.
module dram_porta_arb
   import dram_sched_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
`ifdef DRAM_SCHED_RR_EN
   input  logic              clk,
   input  logic              rst,
`endif
   input  logic              h_req,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_data,
   output logic              h_gnt,
   input  logic              r_req,
   input  logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] r_data,
   output logic              r_gnt,
   output logic              ram_ena,
   output logic              ram_wea,
   output logic [ADDR_W-1:0] ram_addra,
   output logic [DATA_W-1:0] ram_dia
);

`ifdef DRAM_SCHED_RR_EN
   logic last_q, last_d;

   // Grant: a lone requester always wins; on contention the one not granted last wins
   always_comb begin
      h_gnt = 1'b0;
      r_gnt = 1'b0;
      if (h_req && r_req) begin
         if (last_q == HOST) r_gnt = 1'b1;
         else                h_gnt = 1'b1;
      end else begin
         h_gnt = h_req;
         r_gnt = r_req;
      end
   end

   // Pointer only moves when somebody is actually granted
   always_comb begin
      last_d = last_q;
      if (h_gnt)      last_d = HOST;
      else if (r_gnt) last_d = RES;
   end

   // Last-granted pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= HOST;
      else     last_q <= last_d;
   end
`else
   // Fixed priority: result writeback always beats the host loader
   always_comb begin
      r_gnt = r_req;
      h_gnt = h_req & ~r_req;
   end
`endif

   // Port A mux follows the granted requester; idle port drives zeros
   always_comb begin
      ram_addra = '0;
      ram_dia   = '0;
      if (r_gnt) begin
         ram_addra = r_addr;
         ram_dia   = r_data;
      end else if (h_gnt) begin
         ram_addra = h_addr;
         ram_dia   = h_data;
      end
   end

   assign ram_ena = h_gnt | r_gnt;
   assign ram_wea = h_gnt | r_gnt;

endmodule

// File: rtl/dram_sched_ctrl.sv
// Matrix DRAM controller: port B burst read streamer plus port A write arbiter (DRAM_SCHED_RR_EN selects round-robin).
// Latency: 1 cycle ram_enb -> s_valid; done pulses 2+rd_count cycles after start when s_ready stays high.
// Backpressure: full; with s_ready low the DRAM is not re-enabled so dob (s_data) holds the pending word.
module dram_sched_ctrl
   import dram_sched_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] rd_base,
   input  logic [ADDR_W:0]   rd_count,
   output logic              busy,
   output logic              done,
   output logic              ram_enb,
   output logic [ADDR_W-1:0] ram_addrb,
   input  logic [DATA_W-1:0] ram_dob,
   output logic [DATA_W-1:0] s_data,
   output logic              s_valid,
   input  logic              s_ready,
   output logic              s_last,
   input  logic              h_req,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_data,
   output logic              h_gnt,
   input  logic              r_req,
   input  logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] r_data,
   output logic              r_gnt,
   output logic              ram_ena,
   output logic              ram_wea,
   output logic [ADDR_W-1:0] ram_addra,
   output logic [DATA_W-1:0] ram_dia
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     rem_q, rem_d;
   logic                s_valid_q, s_valid_d;
   logic                s_last_q, s_last_d;
   logic                done_q, done_d;
   logic                start_ok, issue, finish;

   // A start in the done cycle is dropped: the burst that just ended owns that cycle
   assign start_ok = (state_q == IDLE) && start && !done_q;
   // Fetch the next word when words remain and the output slot is free or draining
   assign issue    = (state_q == READ) && (rem_q != '0) && (!s_valid_q || s_ready);
   // Burst ends once nothing is left to fetch and the output slot empties this cycle
   assign finish   = (state_q == READ) && (rem_q == '0) && (!s_valid_q || s_ready);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = READ;
         READ:    if (finish)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy    = (state_q == READ);
      ram_enb = issue;
   end

   // Sequencer datapath: address/remaining count load, advance, and output slot tracking
   always_comb begin
      addr_d    = addr_q;
      rem_d     = rem_q;
      s_valid_d = s_valid_q;
      s_last_d  = s_last_q;
      done_d    = finish;
      if (start_ok) begin
         addr_d = rd_base;
         rem_d  = rd_count;
      end else if (issue) begin
         addr_d    = addr_q + ADDR_ONE;
         rem_d     = rem_q - REM_ONE;
         s_valid_d = 1'b1;
         s_last_d  = (rem_q == REM_ONE);
      end else if (s_ready) begin
         s_valid_d = 1'b0;
         s_last_d  = 1'b0;
      end
   end

   // Sequencer datapath registers; reset abandons any burst without a done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         rem_q     <= '0;
         s_valid_q <= 1'b0;
         s_last_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         s_valid_q <= s_valid_d;
         s_last_q  <= s_last_d;
         done_q    <= done_d;
      end
   end

   assign ram_addrb = addr_q;
   assign s_data    = ram_dob;
   assign s_valid   = s_valid_q;
   assign s_last    = s_last_q;
   assign done      = done_q;

   dram_porta_arb #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_porta_arb (
`ifdef DRAM_SCHED_RR_EN
      .clk       (clk),
      .rst       (rst),
`endif
      .h_req     (h_req),
      .h_addr    (h_addr),
      .h_data    (h_data),
      .h_gnt     (h_gnt),
      .r_req     (r_req),
      .r_addr    (r_addr),
      .r_data    (r_data),
      .r_gnt     (r_gnt),
      .ram_ena   (ram_ena),
      .ram_wea   (ram_wea),
      .ram_addra (ram_addra),
      .ram_dia   (ram_dia)
   );

endmodule

// File: tb/tb_dram_sched_ctrl.sv
// Bench for dram_sched_ctrl: drives a behavioural dual-port DRAM, checks streams and grants against a memory model.
// Latency expectations come from burst length plus observed stall cycles.
// Backpressure is exercised with fixed toggling and random s_ready patterns.
module tb_dram_sched_ctrl;

   localparam int AW = 4;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] rd_base;
   logic [AW:0]   rd_count;
   logic          busy, done, ram_enb;
   logic [AW-1:0] ram_addrb;
   logic [DW-1:0] ram_dob;
   logic [DW-1:0] s_data;
   logic          s_valid, s_ready, s_last;
   logic          h_req, r_req, h_gnt, r_gnt;
   logic [AW-1:0] h_addr, r_addr, ram_addra;
   logic [DW-1:0] h_data, r_data, ram_dia;
   logic          ram_ena, ram_wea;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] ref_mem [16];   // expected DRAM contents
   logic          last_win;       // 0 = host granted last, 1 = result granted last
   logic [DW-1:0] dram [16];      // physical DRAM stand-in

   always #5 clk = ~clk;

   dram_sched_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .rd_base(rd_base), .rd_count(rd_count),
      .busy(busy), .done(done), .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
      .h_req(h_req), .h_addr(h_addr), .h_data(h_data), .h_gnt(h_gnt),
      .r_req(r_req), .r_addr(r_addr), .r_data(r_data), .r_gnt(r_gnt),
      .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia)
   );

   // Dual-port DRAM: registered port B read returns the pre-write word on a same-address collision
   always @(posedge clk) begin
      if (ram_ena && ram_wea) dram[ram_addra] <= ram_dia;
      if (ram_enb) ram_dob <= dram[ram_addrb];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string pfx);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_s_valid"}, s_valid, 0);
      chk({pfx, "_s_last"}, s_last, 0);
      chk({pfx, "_ram_enb"}, ram_enb, 0);
      chk({pfx, "_ram_ena"}, ram_ena, 0);
      chk({pfx, "_ram_wea"}, ram_wea, 0);
      chk({pfx, "_h_gnt"}, h_gnt, 0);
      chk({pfx, "_r_gnt"}, r_gnt, 0);
      chk({pfx, "_ram_addrb"}, ram_addrb, 0);
      chk({pfx, "_ram_addra"}, ram_addra, 0);
   endtask

   // One port A cycle: predict the winner, check port A, then commit the write to the model
   task automatic arb_cycle(input logic hq, input logic rq, output logic gh, output logic gr);
      logic eh, er;
      h_req = hq;
      r_req = rq;
      #1;
      eh = 1'b0;
      er = 1'b0;
      if (hq && rq) begin
`ifdef DRAM_SCHED_RR_EN
         if (last_win == 1'b0) er = 1'b1;
         else                  eh = 1'b1;
`else
         er = 1'b1;
`endif
      end else begin
         eh = hq;
         er = rq;
      end
      chk("h_gnt", h_gnt, eh);
      chk("r_gnt", r_gnt, er);
      chk("ram_ena", ram_ena, eh | er);
      chk("ram_wea", ram_wea, eh | er);
      if (er) begin
         chk("addra_res", ram_addra, r_addr);
         chk("dia_res", ram_dia, r_data);
      end else if (eh) begin
         chk("addra_host", ram_addra, h_addr);
         chk("dia_host", ram_dia, h_data);
      end
      tick();
      if (er) begin
         ref_mem[r_addr] = r_data;
         last_win = 1'b1;
      end else if (eh) begin
         ref_mem[h_addr] = h_data;
         last_win = 1'b0;
      end
      h_req = 1'b0;
      r_req = 1'b0;
      gh = eh;
      gr = er;
   endtask

   // mode 0: ready always high, 1: ready toggles 1,0,1,0 from the first word, 2: random ready
   task automatic run_burst(input logic [AW-1:0] base, input int cnt, input int mode);
      logic [DW-1:0] expq[$];
      int idx = 0, issued = 0, stalls = 0;
      logic seen_done = 1'b0;
      logic rdy;
      for (int i = 0; i < cnt; i++) expq.push_back(ref_mem[4'((int'(base) + i) % 16)]);
      rd_base  = base;
      rd_count = 5'(cnt);
      start    = 1'b1;
      #1;
      chk("busy_before_start", busy, 0);
      tick();
      for (int k = 1; k <= 200; k++) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (k % 2 == 0);
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         s_ready  = rdy;
         start    = 1'b1;          // must be ignored while busy and in the done cycle
         rd_base  = 4'($urandom);
         rd_count = 5'($urandom);
         #1;
         if (done) begin
            seen_done = 1'b1;
            chk("done_cycle", k, cnt + 2 + stalls);
            chk("busy_at_done", busy, 0);
            chk("valid_at_done", s_valid, 0);
            break;
         end
         chk("busy", busy, 1);
         if (ram_enb) begin
            chk("addrb", ram_addrb, (int'(base) + issued) % 16);
            issued++;
         end
         if (s_valid) begin
            chk("word_in_range", idx < cnt, 1);
            if (idx < cnt) begin
               chk("s_data", s_data, expq[idx]);
               chk("s_last", s_last, idx == cnt - 1);
            end
            if (rdy) idx++;
            else     stalls++;
         end
         tick();
      end
      chk("done_seen", seen_done, 1);
      chk("handshakes", idx, cnt);
      chk("issued", issued, cnt);
      tick();
      start = 1'b0;
      #1;
      chk("start_at_done_ignored", busy, 0);
      chk("done_single_cycle", done, 0);
   endtask

   initial begin
      logic gh, gr, hp, rp;
      logic [DW-1:0] old_w, new_w;
      rst = 1'b1; start = 1'b0; rd_base = '0; rd_count = '0; s_ready = 1'b0;
      h_req = 1'b0; r_req = 1'b0; h_addr = '0; r_addr = '0; h_data = '0; r_data = '0;
      last_win = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_quiet("reset");
      rst = 1'b0;
      tick();

      // Host loads 0x0A00+i everywhere
      for (int i = 0; i < 16; i++) begin
         h_addr = 4'(i);
         h_data = 16'h0A00 + 16'(i);
         arb_cycle(1'b1, 1'b0, gh, gr);
      end

      run_burst(4'd0, 16, 0);           // full memory, no stalls
      run_burst(4'd4, 4, 1);            // backpressure
      run_burst(4'd14, 4, 0);           // address wrap
      run_burst(4'($urandom), 0, 0);    // empty burst

      // Contention: both request for 4 cycles; winners refresh their request
      h_addr = 4'($urandom); h_data = 16'($urandom);
      r_addr = 4'($urandom); r_data = 16'($urandom);
      for (int c = 0; c < 4; c++) begin
         arb_cycle(1'b1, 1'b1, gh, gr);
         if (gh) begin h_addr = 4'($urandom); h_data = 16'($urandom); end
         if (gr) begin r_addr = 4'($urandom); r_data = 16'($urandom); end
      end
      arb_cycle(1'b1, 1'b0, gh, gr);    // host gets in once result drops

      // Random port A traffic with hold-until-grant requesters
      hp = 1'b0; rp = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (!hp && $urandom_range(0, 1) == 1) begin
            hp = 1'b1; h_addr = 4'($urandom); h_data = 16'($urandom);
         end
         if (!rp && $urandom_range(0, 1) == 1) begin
            rp = 1'b1; r_addr = 4'($urandom); r_data = 16'($urandom);
         end
         arb_cycle(hp, rp, gh, gr);
         if (gh) hp = 1'b0;
         if (gr) rp = 1'b0;
      end

      // Random bursts over the scrambled contents
      for (int b = 0; b < 4; b++) run_burst(4'($urandom), $urandom_range(1, 16), 2);

      // Same-address collision: port B reads 5 while the result writes 5
      s_ready = 1'b1; rd_base = 4'd5; rd_count = 5'd1; start = 1'b1;
      tick();
      start  = 1'b0;
      old_w  = ref_mem[5];
      new_w  = ~old_w;
      r_req  = 1'b1; r_addr = 4'd5; r_data = new_w;
      #1;
      chk("coll_enb", ram_enb, 1);
      chk("coll_addrb", ram_addrb, 5);
      chk("coll_r_gnt", r_gnt, 1);
      tick();
      r_req = 1'b0; ref_mem[5] = new_w; last_win = 1'b1;
      #1;
      chk("coll_valid", s_valid, 1);
      chk("coll_old_word", s_data, old_w);
      tick();
      #1;
      chk("coll_done", done, 1);
      tick();
      run_burst(4'd5, 1, 0);            // now returns the new word

      // Reset mid-burst after three delivered words
      s_ready = 1'b1; rd_base = 4'd0; rd_count = 5'd16; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("pre_reset_valid", s_valid, 1);
      rst = 1'b1;
      #1;
      chk_quiet("midreset");
      tick();
      chk("midreset_no_done", done, 0);
      rst = 1'b0; last_win = 1'b0;
      tick();
      chk("post_reset_no_done", done, 0);
      run_burst(4'd0, 16, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute guard so the run always ends
   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
